// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and pointer synchronisers.
// Helpers work on a fixed 32-bit word; callers zero-extend in and truncate out with casts.
package gray_pkg;

  localparam int unsigned MaxWidth = 32;

  typedef logic [MaxWidth-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray encoding of the all-ones binary value: MSB set, everything else clear.
  function automatic word_t gray_max(input int unsigned width);
    return word_t'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder (prefix XOR from the MSB down).
module gray_to_bin #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter_n.sv
// WIDTH-bit up/down Gray counter with clear, Gray-coded load and wrap flags.
// Binary and Gray copies are both registered so Output never passes through decode logic.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 3,  // minimum 2
  parameter bit          STICKY      = 1'b1,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Value,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Bin_Output,
  output logic             Overflow,
  output logic             Underflow
);

  localparam logic [WIDTH-1:0] ResetBin  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ResetGray = WIDTH'(bin2gray(word_t'(ResetBin)));
  localparam logic [WIDTH-1:0] GrayMax   = WIDTH'(gray_max(WIDTH));

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  gray_to_bin #(
    .WIDTH(WIDTH)
  ) u_load_dec (
    .gray(Load_Value),
    .bin (load_bin)
  );

  always_comb begin
    b_d   = b_q;
    g_d   = g_q;
    // Non-sticky flags fall back to zero on every edge unless a wrap re-asserts them.
    ovf_d = STICKY & ovf_q;
    unf_d = STICKY & unf_q;
    if (Clear) begin
      b_d   = '0;
      g_d   = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (Load) begin
      b_d = load_bin;
      g_d = Load_Value;
    end else if (En) begin
      if (Up) begin
        b_d = b_q + 1'b1;
        if (g_q == GrayMax) ovf_d = 1'b1;
      end else begin
        b_d = b_q - 1'b1;
        if (b_q == '0) unf_d = 1'b1;
      end
      g_d = WIDTH'(bin2gray(word_t'(b_d)));
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      b_q   <= ResetBin;
      g_q   <= ResetGray;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      b_q   <= b_d;
      g_q   <= g_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign Output     = g_q;
  assign Bin_Output = b_q;
  assign Overflow   = ovf_q;
  assign Underflow  = unf_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n across three configurations sharing one clock.
module tb_gray_counter_n;

  logic Clk;
  int   n_tests = 0;
  int   n_fail  = 0;

  // A: WIDTH=3 STICKY=1 RESET_VALUE=0
  logic       a_rst, a_en, a_up, a_clr, a_ld;
  logic [2:0] a_lv, a_out, a_bin;
  logic       a_ovf, a_unf;
  // B: WIDTH=4 STICKY=0 RESET_VALUE=0
  logic       b_rst, b_en, b_up, b_clr, b_ld;
  logic [3:0] b_lv, b_out, b_bin;
  logic       b_ovf, b_unf;
  // C: WIDTH=4 STICKY=1 RESET_VALUE=5
  logic       c_rst, c_en, c_up, c_clr, c_ld;
  logic [3:0] c_lv, c_out, c_bin;
  logic       c_ovf, c_unf;

  gray_counter_n #(.WIDTH(3), .STICKY(1'b1), .RESET_VALUE(0)) u_a (
    .Clk(Clk), .Reset(a_rst), .En(a_en), .Up(a_up), .Clear(a_clr), .Load(a_ld),
    .Load_Value(a_lv), .Output(a_out), .Bin_Output(a_bin), .Overflow(a_ovf), .Underflow(a_unf)
  );

  gray_counter_n #(.WIDTH(4), .STICKY(1'b0), .RESET_VALUE(0)) u_b (
    .Clk(Clk), .Reset(b_rst), .En(b_en), .Up(b_up), .Clear(b_clr), .Load(b_ld),
    .Load_Value(b_lv), .Output(b_out), .Bin_Output(b_bin), .Overflow(b_ovf), .Underflow(b_unf)
  );

  gray_counter_n #(.WIDTH(4), .STICKY(1'b1), .RESET_VALUE(5)) u_c (
    .Clk(Clk), .Reset(c_rst), .En(c_en), .Up(c_up), .Clear(c_clr), .Load(c_ld),
    .Load_Value(c_lv), .Output(c_out), .Bin_Output(c_bin), .Overflow(c_ovf), .Underflow(c_unf)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [31:0] gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic [2:0] seq3 [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  logic [3:0] prev;

  initial begin
    {a_rst, a_en, a_up, a_clr, a_ld, a_lv} = '0;
    {b_rst, b_en, b_up, b_clr, b_ld, b_lv} = '0;
    {c_rst, c_en, c_up, c_clr, c_ld, c_lv} = '0;
    #101;
    chk("a_reset_out", a_out, 3'b000);
    chk("a_reset_flags", {a_ovf, a_unf}, 2'b00);
    chk("c_reset_out", c_out, 4'b0111);
    chk("c_reset_bin", c_bin, 4'd5);

    // A: count up through the wrap, overflow sticks
    a_rst = 1'b1; a_en = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("a_up_out", a_out, seq3[i]);
      chk("a_up_ovf", a_ovf, (i == 7));
      chk("a_up_unf", a_unf, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("a_sticky_out", a_out, gray((i + 1) % 8));
      chk("a_sticky_ovf", a_ovf, 1'b1);
      chk("a_sticky_unf", a_unf, 1'b0);
    end

    // A: reset, then count down through the wrap
    a_rst = 1'b0; a_en = 1'b0;
    #2;
    chk("a_rst_ovf", a_ovf, 1'b0);
    a_rst = 1'b1; a_en = 1'b1; a_up = 1'b0;
    tick();
    chk("a_dn1_out", a_out, 3'b100);
    chk("a_dn1_bin", a_bin, 3'b111);
    chk("a_dn1_flags", {a_ovf, a_unf}, 2'b01);
    tick();
    chk("a_dn2_out", a_out, 3'b101);
    chk("a_dn2_bin", a_bin, 3'b110);
    chk("a_dn2_unf", a_unf, 1'b1);

    // A: load beats enable, flags held
    a_ld = 1'b1; a_lv = 3'b110; a_up = 1'b1;
    tick();
    chk("a_ld_out", a_out, 3'b110);
    chk("a_ld_bin", a_bin, 3'b100);
    chk("a_ld_flags", {a_ovf, a_unf}, 2'b01);
    a_ld = 1'b0;
    tick();
    chk("a_after_ld_out", a_out, 3'b111);
    chk("a_after_ld_bin", a_bin, 3'b101);
    a_en = 1'b0;
    tick();
    chk("a_hold_out", a_out, 3'b111);
    chk("a_hold_unf", a_unf, 1'b1);

    // A: loading max never sets overflow; then wrap up so both flags are set
    a_ld = 1'b1; a_lv = 3'b100;
    tick();
    chk("a_ldmax_bin", a_bin, 3'b111);
    chk("a_ldmax_ovf", a_ovf, 1'b0);
    a_ld = 1'b0; a_en = 1'b1; a_up = 1'b1;
    tick();
    chk("a_both_out", a_out, 3'b000);
    chk("a_both_flags", {a_ovf, a_unf}, 2'b11);

    // A: clear wins over load and enable
    a_clr = 1'b1; a_ld = 1'b1; a_lv = 3'b110;
    tick();
    chk("a_clr_out", a_out, 3'b000);
    chk("a_clr_bin", a_bin, 3'b000);
    chk("a_clr_flags", {a_ovf, a_unf}, 2'b00);
    a_clr = 1'b0; a_ld = 1'b0; a_en = 1'b0;

    // B: pulsed overflow over a full lap, single-bit steps
    b_rst = 1'b1; b_en = 1'b1; b_up = 1'b1;
    prev = b_out;
    chk("b_start_out", b_out, 4'b0000);
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("b_onebit", $countones(b_out ^ prev), 1);
      chk("b_up_out", b_out, gray(k % 16));
      chk("b_pulse_ovf", b_ovf, (k == 16));
      prev = b_out;
    end
    b_up = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("b_rev_onebit", $countones(b_out ^ prev), 1);
      chk("b_rev_out", b_out, (k == 0) ? 4'b0000 : 4'b1000);
      chk("b_rev_unf", b_unf, (k == 1));
      prev = b_out;
    end
    b_en = 1'b0;
    tick();
    chk("b_unf_drop", b_unf, 1'b0);
    chk("b_hold_out", b_out, 4'b1000);

    // C: walk to binary 4 with both flags set, then async reset mid-cycle
    c_rst = 1'b1; c_en = 1'b1; c_up = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("c_dn_bin", c_bin, (k < 5) ? 4 - k : 15);
    end
    chk("c_dn_unf", c_unf, 1'b1);
    c_up = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("c_mid_out", c_out, 4'b0110);
    chk("c_mid_flags", {c_ovf, c_unf}, 2'b11);
    #3;
    c_rst = 1'b0;
    #1;
    chk("c_async_out", c_out, 4'b0111);
    chk("c_async_bin", c_bin, 4'd5);
    chk("c_async_flags", {c_ovf, c_unf}, 2'b00);
    #2;
    c_rst = 1'b1;
    tick();
    chk("c_resume_out", c_out, 4'b0101);
    chk("c_resume_bin", c_bin, 4'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
- Parametrised successor to the team's fixed 3-bit Gray counter.
- WIDTH-bit Gray-code counter with:
  - up/down direction
  - synchronous clear
  - parallel load of a Gray value
  - overflow/underflow flags, either sticky or pulsed
- Used as a pointer/sequence generator wherever a single-bit-change count is needed, e.g. future async FIFO pointers and P-series test fixtures.

Parameters:
- WIDTH, 3: counter width in bits, minimum 2.
- STICKY, 1: 1 = Overflow/Underflow hold until Reset or Clear; 0 = one-cycle pulses.
- RESET_VALUE, 0: binary value loaded on Reset; Output = its Gray encoding.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- En  input  1  count enable.
- Up  input  1  1 = count up, 0 = count down; sampled only when counting.
- Clear  input  1  synchronous clear to binary 0.
- Load  input  1  synchronous load.
- Load_Value  input  WIDTH  Gray-coded value to load.
- Output  output  WIDTH  registered Gray count.
- Bin_Output  output  WIDTH  registered binary equivalent of Output.
- Overflow  output  1  up-wrap flag.
- Underflow  output  1  down-wrap flag.

Behaviour:
- State: binary register B and Gray register G.
  - Invariant: G == B ^ (B >> 1) at all times.
  - Output = G and Bin_Output = B, both driven straight from flops (no combinational decode on Output).
- Reset low, asynchronous:
  - B = RESET_VALUE, G = gray(RESET_VALUE).
  - Overflow = 0, Underflow = 0.
  - Release is synchronous to the next Clk edge; the first count happens on the first rising edge with Reset high and En = 1.
- Per rising edge, priority Clear > Load > En:
  - Clear=1: B=0, G=0, Overflow=0, Underflow=0, regardless of Load/En.
  - Load=1:
    - B = gray_to_bin(Load_Value), G = Load_Value.
    - Flags: STICKY=1 holds them; STICKY=0 clears them.
    - Never sets a flag, even when loading max or 0.
  - En=1, Up=1:
    - B = B+1 mod 2^WIDTH.
    - If old B == 2^WIDTH-1, set Overflow.
  - En=1, Up=0:
    - B = B-1 mod 2^WIDTH.
    - If old B == 0, set Underflow.
  - En=0: hold everything.
    - STICKY=0: flags drop to 0.
    - STICKY=1: flags hold.
- Latency: one cycle from a sampled control to updated Output, Bin_Output and flags.
- STICKY=0: a flag is high exactly for the cycle after the wrapping edge.
- Flag independence: Overflow and Underflow are independent. Both may be 1 in STICKY mode after up-wrap then down-wrap.
- Direction reversal mid-count is legal; each step changes exactly one bit of Output.
- Load with Load_Value equal to current G is legal and is a no-op apart from flag handling.
- Width rule: all arithmetic is WIDTH bits, with no carry-out register.

Decomposition:
- Package gray_pkg:
  - function bin2gray(WIDTH), i.e. b ^ (b>>1)
  - constant-width helper gray_max(WIDTH) = Gray encoding of 2^WIDTH-1, i.e. 1 followed by zeros
- Sub-module gray_to_bin:
  - parameter WIDTH
  - combinational prefix XOR from MSB: b[i] = ^g[WIDTH-1:i]
  - reused later by FIFO pointer synchronisers
- The counter instantiates gray_to_bin once, on Load_Value.

Test Plan:
- WIDTH=3, STICKY=1, Reset low 100 ns, release, En=1, Up=1 for 9 edges:
  - Output sequence 000,001,011,010,110,111,101,100,000.
  - Overflow rises on the edge producing 000 and stays 1 for 20 further edges.
  - Underflow stays 0.
- Same config, after reset, En=1, Up=0 for 2 edges:
  - Output 000 → 100 → 101.
  - Underflow=1 after first edge and held.
  - Bin_Output 000 → 111 → 110.
- Load=1, Load_Value=110 with En=1 concurrently, then En=1, Up=1:
  - Output=110, Bin_Output=100 after load edge.
  - Next edge Output=111.
  - Flags unchanged by the load.
- Clear=1 together with Load=1 and En=1 while Overflow=1:
  - Next edge Output=000, Overflow=0, Underflow=0.
- WIDTH=4, STICKY=0, count up from reset for 16 edges:
  - Overflow high for exactly one cycle after the 16th edge.
  - Every consecutive Output pair differs in exactly one bit (checker on all edges).
- Assert Reset low mid-count (Output=0110, WIDTH=4, RESET_VALUE=5) between clock edges:
  - Output becomes 0111 immediately, before the next edge.
  - Flags are 0.
  - Counting resumes from binary 6 after release.
